// File: rtl/spi_lcd_ctrl_pkg.sv
// spi_lcd_pkg: shared types and constants for the SPI LCD transfer controller.
//   - spi_state_e   : transfer FSM states
//   - SPI_WORD_W    : payload width accepted from the command sequencer
//   - SPI_FRAME_BITS: bits shifted out per word (payload plus leading pad bit)
//   - *_DEF         : default CLK_DIV / CS_SETUP / CS_HOLD values
//   - cnt_width()   : counter width for counting 0..n-1, never less than 1
package spi_lcd_pkg;

    localparam int unsigned SPI_WORD_W       = 7;
    localparam int unsigned SPI_FRAME_BITS   = 8;
    localparam int unsigned SPI_CLK_DIV_DEF  = 4;
    localparam int unsigned SPI_CS_SETUP_DEF = 2;
    localparam int unsigned SPI_CS_HOLD_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_SHIFT,
        ST_HOLD,
        ST_WAIT
    } spi_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_lcd_ctrl_if.sv
// spi_lcd_ctrl_if: word handshake between the command sequencer (master)
// and the transfer controller (slave).
//   tx_valid/tx_ready : valid/ready handshake
//   tx_data           : 7-bit payload word
//   tx_last           : release CS after this word
//   tx_dc             : data/command flag (only with SPI_LCD_DC_EN defined)
interface spi_lcd_ctrl_if;
    import spi_lcd_pkg::*;

    logic                  tx_valid;
    logic                  tx_ready;
    logic [SPI_WORD_W-1:0] tx_data;
    logic                  tx_last;
`ifdef SPI_LCD_DC_EN
    logic                  tx_dc;
`endif

    modport master (
`ifdef SPI_LCD_DC_EN
        output tx_dc,
`endif
        output tx_valid, tx_data, tx_last,
        input  tx_ready
    );

    modport slave (
`ifdef SPI_LCD_DC_EN
        input  tx_dc,
`endif
        input  tx_valid, tx_data, tx_last,
        output tx_ready
    );

endinterface

// File: rtl/spi_lcd_ctrl_sclk_div.sv
// spi_sclk_div: SCLK half-period divider for the SPI LCD controller.
//   clk, rst : system clock, asynchronous active-high reset
//   clr_i    : clear counter and force sclk low
//   en_i     : run the divider (sclk toggles every CLK_DIV enabled cycles)
//   sclk_o   : registered SPI clock, idles low
//   fall_o   : high in the cycle whose closing edge drives sclk low
module spi_sclk_div
    import spi_lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic sclk_o,
    output logic fall_o
);

    localparam int unsigned     HP_W    = cnt_width(CLK_DIV);
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(CLK_DIV - 1);

    logic [HP_W-1:0] hp_q;
    logic            sclk_q;
    logic            half_end;

    assign half_end = en_i && (hp_q == HP_LAST);
    // Look-ahead so the FSM can register sh_en on the same edge as the fall.
    assign fall_o   = half_end && sclk_q;
    assign sclk_o   = sclk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_q   <= '0;
            sclk_q <= 1'b0;
        end else if (clr_i) begin
            hp_q   <= '0;
            sclk_q <= 1'b0;
        end else if (en_i) begin
            if (half_end) begin
                hp_q   <= '0;
                sclk_q <= ~sclk_q;
            end else begin
                hp_q   <= hp_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_lcd_ctrl.sv
// spi_lcd_ctrl: transfer controller for the SPI LCD link.
// Accepts 7-bit words over a valid/ready handshake and drives the 8-bit
// output shift stage (load/shift strobes), SCLK (mode 0) and cs_n, with
// multi-word bursts held under one CS assertion.
//   clk, rst   : system clock, asynchronous active-high reset
//   tx_if      : word handshake (slave side)
//   sh_load    : one-cycle parallel load strobe
//   sh_en      : one-cycle shift strobe
//   sh_data    : word presented to the shift stage
//   sclk, cs_n : SPI clock and active-low chip select
//   busy       : FSM not in IDLE
//   done       : one-cycle pulse per completed word
//   lcd_dc     : data/command line (only with SPI_LCD_DC_EN defined)
// Optional feature macro: SPI_LCD_DC_EN.
module spi_lcd_ctrl
    import spi_lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV  = SPI_CLK_DIV_DEF,
    parameter int unsigned CS_SETUP = SPI_CS_SETUP_DEF,
    parameter int unsigned CS_HOLD  = SPI_CS_HOLD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_lcd_ctrl_if.slave         tx_if,
    output logic                  sh_load,
    output logic                  sh_en,
    output logic [SPI_WORD_W-1:0] sh_data,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  busy,
`ifdef SPI_LCD_DC_EN
    output logic                  lcd_dc,
`endif
    output logic                  done
);

    localparam int unsigned     CNT_W      = cnt_width((CS_SETUP > CS_HOLD ? CS_SETUP : CS_HOLD) + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP == 0 ? 0 : CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD == 0 ? 0 : CS_HOLD - 1);
    localparam logic [2:0]       LAST_BIT   = 3'(SPI_FRAME_BITS - 1);

    spi_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            bit_q;
    logic                  last_q;
    logic                  tx_ready_q;
    logic                  sh_load_q;
    logic                  sh_en_q;
    logic [SPI_WORD_W-1:0] sh_data_q;
    logic                  cs_n_q;
    logic                  busy_q;
    logic                  done_q;
`ifdef SPI_LCD_DC_EN
    logic                  lcd_dc_q;
`endif
    logic                  fall;
    logic                  accept;

    assign accept = tx_if.tx_valid && tx_ready_q;

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == ST_LOAD),
        .en_i   (state_q == ST_SHIFT),
        .sclk_o (sclk),
        .fall_o (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            last_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            sh_load_q  <= 1'b0;
            sh_en_q    <= 1'b0;
            sh_data_q  <= '0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPI_LCD_DC_EN
            lcd_dc_q   <= 1'b0;
`endif
        end else begin
            sh_load_q <= 1'b0;
            sh_en_q   <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_ready_q <= 1'b1;
                    if (accept) begin
                        sh_data_q  <= tx_if.tx_data;
                        last_q     <= tx_if.tx_last;
`ifdef SPI_LCD_DC_EN
                        lcd_dc_q   <= tx_if.tx_dc;
`endif
                        tx_ready_q <= 1'b0;
                        cs_n_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        if (CS_SETUP == 0) begin
                            state_q   <= ST_LOAD;
                            sh_load_q <= 1'b1;
                        end else begin
                            state_q   <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_q   <= ST_LOAD;
                        sh_load_q <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_SHIFT;
                    bit_q   <= '0;
                end
                ST_SHIFT: begin
                    if (fall) begin
                        if (bit_q == LAST_BIT) begin
                            cnt_q <= '0;
                            if (last_q) begin
                                state_q    <= ST_HOLD;
                            end else begin
                                state_q    <= ST_WAIT;
                                done_q     <= 1'b1;
                                tx_ready_q <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            sh_en_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q    <= ST_IDLE;
                        cs_n_q     <= 1'b1;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (accept) begin
                        sh_data_q  <= tx_if.tx_data;
                        last_q     <= tx_if.tx_last;
`ifdef SPI_LCD_DC_EN
                        lcd_dc_q   <= tx_if.tx_dc;
`endif
                        tx_ready_q <= 1'b0;
                        state_q    <= ST_LOAD;
                        sh_load_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_if.tx_ready = tx_ready_q;
    assign sh_load        = sh_load_q;
    assign sh_en          = sh_en_q;
    assign sh_data        = sh_data_q;
    assign cs_n           = cs_n_q;
    assign busy           = busy_q;
    assign done           = done_q;
`ifdef SPI_LCD_DC_EN
    assign lcd_dc         = lcd_dc_q;
`endif

endmodule

// File: tb/tb_spi_lcd_ctrl.sv
// tb_spi_lcd_ctrl: directed self-checking bench for spi_lcd_ctrl.
// Two instances: A (CLK_DIV=2, CS_SETUP=1, CS_HOLD=1) and
// B (CLK_DIV=1, CS_SETUP=0, CS_HOLD=2). A falling-edge model of the
// 8-bit shift stage reconstructs the serial stream seen at sclk rises.
module tb_spi_lcd_ctrl;
    import spi_lcd_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_lcd_ctrl_if bus_a ();
    spi_lcd_ctrl_if bus_b ();

    logic       a_load, a_en, a_sclk, a_csn, a_busy, a_done;
    logic       b_load, b_en, b_sclk, b_csn, b_busy, b_done;
    logic [6:0] a_data, b_data;
`ifdef SPI_LCD_DC_EN
    logic       a_dc, b_dc;
`endif

    spi_lcd_ctrl #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut_a (
        .clk(clk), .rst(rst), .tx_if(bus_a),
        .sh_load(a_load), .sh_en(a_en), .sh_data(a_data), .sclk(a_sclk),
        .cs_n(a_csn), .busy(a_busy),
`ifdef SPI_LCD_DC_EN
        .lcd_dc(a_dc),
`endif
        .done(a_done)
    );

    spi_lcd_ctrl #(.CLK_DIV(1), .CS_SETUP(0), .CS_HOLD(2)) dut_b (
        .clk(clk), .rst(rst), .tx_if(bus_b),
        .sh_load(b_load), .sh_en(b_en), .sh_data(b_data), .sclk(b_sclk),
        .cs_n(b_csn), .busy(b_busy),
`ifdef SPI_LCD_DC_EN
        .lcd_dc(b_dc),
`endif
        .done(b_done)
    );

    typedef struct packed {
        logic       sclk, cs_n, sh_load, sh_en, done, busy, ready, dc;
        logic [6:0] data;
    } smp_t;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [127:0] rise_m, en_m, load_m, done_m, csn_m, rdy_m, busy_m, sclk_m, dc_m;
    logic [15:0]  rx;
    logic [6:0]   data_log [128];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic smp_t get_smp(input int unsigned sel);
        smp_t s;
        if (sel == 0) begin
            s.sclk = a_sclk; s.cs_n = a_csn; s.sh_load = a_load; s.sh_en = a_en;
            s.done = a_done; s.busy = a_busy; s.ready = bus_a.tx_ready; s.data = a_data;
        end else begin
            s.sclk = b_sclk; s.cs_n = b_csn; s.sh_load = b_load; s.sh_en = b_en;
            s.done = b_done; s.busy = b_busy; s.ready = bus_b.tx_ready; s.data = b_data;
        end
`ifdef SPI_LCD_DC_EN
        s.dc = (sel == 0) ? a_dc : b_dc;
`else
        s.dc = 1'b0;
`endif
        return s;
    endfunction

    task automatic drive(input int unsigned sel, input logic v, input logic [6:0] d,
                         input logic l, input logic dc);
        if (sel == 0) begin
            bus_a.tx_valid = v; bus_a.tx_data = d; bus_a.tx_last = l;
`ifdef SPI_LCD_DC_EN
            bus_a.tx_dc = dc;
`endif
        end else begin
            bus_b.tx_valid = v; bus_b.tx_data = d; bus_b.tx_last = l;
`ifdef SPI_LCD_DC_EN
            bus_b.tx_dc = dc;
`endif
        end
        if (dc) begin end
    endtask

    // Offer word d0 once ready, switch the offered word to d1 right after
    // acceptance, drop valid after sampling cycle drop_rel. Records per
    // cycle (rel 0 = acceptance edge) into the *_m masks and rx.
    task automatic run_seq(input int unsigned sel,
                           input logic [6:0] d0, input logic l0, input logic dc0,
                           input logic [6:0] d1, input logic l1, input logic dc1,
                           input int unsigned drop_rel, input int unsigned ncyc);
        smp_t        s;
        logic        prev;
        logic [7:0]  sr;
        int unsigned w;
        rise_m = '0; en_m = '0; load_m = '0; done_m = '0; csn_m = '0;
        rdy_m = '0; busy_m = '0; sclk_m = '0; dc_m = '0; rx = '0; sr = '0;
        w = 0;
        @(negedge clk);
        s = get_smp(sel);
        while (!s.ready && w < 100) begin
            @(negedge clk);
            s = get_smp(sel);
            w++;
        end
        check_eq("ready_wait", s.ready, 1);
        if (!s.ready) return;
        prev = s.sclk;
        drive(sel, 1'b1, d0, l0, dc0);
        for (int unsigned rel = 0; rel <= ncyc; rel++) begin
            @(negedge clk);
            s = get_smp(sel);
            if (s.sclk && !prev) begin
                rise_m[rel] = 1'b1;
                rx = {rx[14:0], sr[7]};
            end
            prev = s.sclk;
            if (s.sh_load)    sr = {1'b0, s.data};
            else if (s.sh_en) sr = {sr[6:0], 1'b0};
            en_m[rel]   = s.sh_en;   load_m[rel] = s.sh_load; done_m[rel] = s.done;
            csn_m[rel]  = s.cs_n;    rdy_m[rel]  = s.ready;   busy_m[rel] = s.busy;
            sclk_m[rel] = s.sclk;    dc_m[rel]   = s.dc;
            data_log[rel] = s.data;
            if (rel == 0)        drive(sel, 1'b1, d1, l1, dc1);
            if (rel == drop_rel) drive(sel, 1'b0, d1, l1, dc1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        smp_t         s;
        logic [127:0] exp;
        rst = 1'b1;
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset state
        s = get_smp(0);
        check_eq("rst_a", {s.cs_n, s.sclk, s.sh_load, s.sh_en, s.done, s.busy, s.ready, s.data},
                 {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00});
        s = get_smp(1);
        check_eq("rst_b", {s.cs_n, s.sclk, s.busy, s.ready}, 4'b1000);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rdy_after_rst", bus_a.tx_ready, 1);

        // Reset mid-SHIFT: at rel 20 of a CLK_DIV=2 word sclk is high
        run_seq(0, 7'h7F, 1'b1, 1'b0, 7'h7F, 1'b1, 1'b0, 0, 20);
        check_eq("pre_rst_sclk", sclk_m[20], 1);
        #2 rst = 1'b1;
        #1 s = get_smp(0);
        check_eq("async_rst", {s.cs_n, s.sclk, s.sh_en, s.busy}, 4'b1000);
        @(negedge clk);
        check_eq("rdy_in_rst", bus_a.tx_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rdy_post_rst", {bus_a.tx_ready, a_csn}, 2'b11);

        // Single word 0x55, last=1; a different word stays offered during the transfer
        run_seq(0, 7'h55, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b0, 34, 37);
        check_eq("s_load",  load_m, 128'h1 << 1);
        check_eq("s_rise",  rise_m, 128'h1_1111_1110);
        check_eq("s_shen",  en_m,   128'h4444_4440);
        check_eq("s_done",  done_m, 128'h1 << 35);
        check_eq("s_csn",   csn_m,  128'h7 << 35);
        check_eq("s_rdy",   rdy_m,  128'h7 << 35);
        check_eq("s_busy",  busy_m, (128'h1 << 35) - 1);
        check_eq("s_rx",    rx,     16'h0055);
        check_eq("s_data",  {data_log[30], data_log[37]}, {7'h55, 7'h55});

        // Two-word burst: 0x12 (last=0) then 0x34 (last=1)
        run_seq(0, 7'h12, 1'b0, 1'b0, 7'h34, 1'b1, 1'b0, 35, 70);
        exp = '0;
        for (int i = 0; i < 8; i++) begin
            exp[4 + 4*i]  = 1'b1;
            exp[38 + 4*i] = 1'b1;
        end
        check_eq("b_rise",  rise_m, exp);
        check_eq("b_nrise", $countones(rise_m), 16);
        check_eq("b_load",  load_m, (128'h1 << 1) | (128'h1 << 35));
        check_eq("b_done",  done_m, (128'h1 << 34) | (128'h1 << 69));
        check_eq("b_csn",   csn_m,  128'h3 << 69);
        check_eq("b_rdy",   rdy_m,  (128'h1 << 34) | (128'h3 << 69));
        check_eq("b_rx",    rx,     16'h1234);
        check_eq("b_data",  {data_log[34], data_log[36]}, {7'h12, 7'h34});

        // Back-to-back single words on CLK_DIV=1, CS_SETUP=0, CS_HOLD=2
        run_seq(1, 7'h3C, 1'b1, 1'b1, 7'h0F, 1'b1, 1'b0, 20, 41);
        exp = '0;
        for (int i = 0; i < 8; i++) begin
            exp[2 + 2*i]  = 1'b1;
            exp[22 + 2*i] = 1'b1;
        end
        check_eq("f_rise",  rise_m, exp);
        check_eq("f_sclk",  sclk_m, exp);
        check_eq("f_load",  load_m, (128'h1 << 0) | (128'h1 << 20));
        check_eq("f_done",  done_m, (128'h1 << 19) | (128'h1 << 39));
        check_eq("f_csn",   csn_m,  (128'h1 << 19) | (128'h7 << 39));
        check_eq("f_rx",    rx,     16'h3C0F);
`ifdef SPI_LCD_DC_EN
        check_eq("f_dc",    dc_m,   (128'h1 << 20) - 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
